// File: rtl/bforge_apb_decoder_n_if.sv
// rtl/bforge_apb_decoder_n_if.sv - initiator-side and target-side APB signal bundle for the 1-to-N decoder
interface bforge_apb_decoder_n_if #(
  parameter int NUM_TARGETS = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32
);
  // initiator side
  logic                              s_psel;
  logic                              s_penable;
  logic                              s_pwrite;
  logic [ADDR_WIDTH-1:0]             s_paddr;
  logic [DATA_WIDTH-1:0]             s_pwdata;
  logic [DATA_WIDTH/8-1:0]           s_pstrb;
  logic [2:0]                        s_pprot;
  logic [DATA_WIDTH-1:0]             s_prdata;
  logic                              s_pready;
  logic                              s_pslverr;
  // target side
  logic [NUM_TARGETS-1:0]            m_psel;
  logic                              m_penable;
  logic                              m_pwrite;
  logic [ADDR_WIDTH-1:0]             m_paddr;
  logic [DATA_WIDTH-1:0]             m_pwdata;
  logic [DATA_WIDTH/8-1:0]           m_pstrb;
  logic [2:0]                        m_pprot;
  logic [NUM_TARGETS*DATA_WIDTH-1:0] m_prdata;
  logic [NUM_TARGETS-1:0]            m_pready;
  logic [NUM_TARGETS-1:0]            m_pslverr;

  // decoder view
  modport slave (
    input  s_psel, s_penable, s_pwrite, s_paddr, s_pwdata, s_pstrb, s_pprot,
    output s_prdata, s_pready, s_pslverr,
    output m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, m_pstrb, m_pprot,
    input  m_prdata, m_pready, m_pslverr
  );

  // environment view: drives the initiator requests and the target responses
  modport master (
    output s_psel, s_penable, s_pwrite, s_paddr, s_pwdata, s_pstrb, s_pprot,
    input  s_prdata, s_pready, s_pslverr,
    input  m_psel, m_penable, m_pwrite, m_paddr, m_pwdata, m_pstrb, m_pprot,
    output m_prdata, m_pready, m_pslverr
  );
endinterface

// File: rtl/bforge_apb_decoder_n.sv
// rtl/bforge_apb_decoder_n.sv - registered APB4 1-to-N decoder with unmapped-address and stall-timeout errors
module bforge_apb_decoder_n #(
  parameter int                    NUM_TARGETS    = 4,
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    WIN_BITS       = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                    TIMEOUT_CYCLES = 16
) (
  input logic                   PCLK,
  input logic                   PRESETn,
  bforge_apb_decoder_n_if.slave bus
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
  localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TO_EN  = (TIMEOUT_CYCLES > 0);
  // counter value seen during the last permitted ACCESS cycle
  localparam logic [CNT_W-1:0]      TO_LAST = CNT_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [ADDR_WIDTH-1:0] NT_A    = ADDR_WIDTH'(NUM_TARGETS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_T_SETUP,
    ST_T_ACCESS,
    ST_ERR,
    ST_RESP
  } state_t;

  state_t                  r_state;
  logic [IDX_W-1:0]        r_idx;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_abort;
  logic [NUM_TARGETS-1:0]  r_m_psel;
  logic                    r_m_penable;
  logic                    r_m_pwrite;
  logic [ADDR_WIDTH-1:0]   r_m_paddr;
  logic [DATA_WIDTH-1:0]   r_m_pwdata;
  logic [STRB_W-1:0]       r_m_pstrb;
  logic [2:0]              r_m_pprot;
  logic [DATA_WIDTH-1:0]   r_s_prdata;
  logic                    r_s_pready;
  logic                    r_s_pslverr;

  logic [ADDR_WIDTH-1:0]   w_off;
  logic [ADDR_WIDTH-1:0]   w_win;
  logic                    w_hit;
  logic [IDX_W-1:0]        w_idx;
  logic                    w_tgt_ready;
  logic                    w_tgt_err;
  logic [DATA_WIDTH-1:0]   w_tgt_rdata;
  logic                    w_abort;

  // Window decode. Addresses below the base fail the compare; a map that would
  // wrap past the top of the address space simply has no addresses there.
  assign w_off = bus.s_paddr - BASE_ADDR;
  assign w_win = w_off >> WIN_BITS;
  assign w_hit = (bus.s_paddr >= BASE_ADDR) && (w_win < NT_A);
  assign w_idx = w_win[IDX_W-1:0];

  // Response of the target captured at SETUP
  assign w_tgt_ready = bus.m_pready[r_idx];
  assign w_tgt_err   = bus.m_pslverr[r_idx];
  assign w_tgt_rdata = bus.m_prdata[r_idx*DATA_WIDTH +: DATA_WIDTH];

  // An initiator that lets psel fall before seeing pready has walked away;
  // its response must not be presented.
  assign w_abort = r_abort | ~bus.s_psel;

  // Transfer sequencing: decode in IDLE, run the target transfer, present one response
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_abort     <= 1'b0;
      r_m_psel    <= '0;
      r_m_penable <= 1'b0;
      r_m_pwrite  <= 1'b0;
      r_m_paddr   <= '0;
      r_m_pwdata  <= '0;
      r_m_pstrb   <= '0;
      r_m_pprot   <= '0;
      r_s_prdata  <= '0;
      r_s_pready  <= 1'b0;
      r_s_pslverr <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.s_psel && !bus.s_penable) begin
            r_m_pwrite <= bus.s_pwrite;
            r_m_paddr  <= bus.s_paddr;
            r_m_pwdata <= bus.s_pwdata;
            r_m_pstrb  <= bus.s_pstrb;
            r_m_pprot  <= bus.s_pprot;
            r_idx      <= w_idx;
            r_cnt      <= '0;
            r_abort    <= 1'b0;
            if (w_hit) begin
              r_m_psel <= NUM_TARGETS'(1) << w_idx;
              r_state  <= ST_T_SETUP;
            end else begin
              r_state  <= ST_ERR;
            end
          end
        end

        ST_T_SETUP: begin
          r_abort     <= w_abort;
          r_m_penable <= 1'b1;
          r_state     <= ST_T_ACCESS;
        end

        ST_T_ACCESS: begin
          r_abort <= w_abort;
          r_cnt   <= r_cnt + 1'b1;
          if (w_tgt_ready) begin
            r_m_psel    <= '0;
            r_m_penable <= 1'b0;
            r_s_pready  <= ~w_abort;
            r_s_pslverr <= ~w_abort & w_tgt_err;
            r_s_prdata  <= (!w_abort && !r_m_pwrite) ? w_tgt_rdata : '0;
            r_state     <= ST_RESP;
          end else if (TO_EN && (r_cnt == TO_LAST)) begin
            r_m_psel    <= '0;
            r_m_penable <= 1'b0;
            r_s_pready  <= ~w_abort;
            r_s_pslverr <= ~w_abort;
            r_s_prdata  <= '0;
            r_state     <= ST_RESP;
          end
        end

        ST_ERR: begin
          r_s_pready  <= ~w_abort;
          r_s_pslverr <= ~w_abort;
          r_s_prdata  <= '0;
          r_state     <= ST_RESP;
        end

        ST_RESP: begin
          r_s_pready  <= 1'b0;
          r_s_pslverr <= 1'b0;
          r_s_prdata  <= '0;
          r_state     <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.m_psel    = r_m_psel;
  assign bus.m_penable = r_m_penable;
  assign bus.m_pwrite  = r_m_pwrite;
  assign bus.m_paddr   = r_m_paddr;
  assign bus.m_pwdata  = r_m_pwdata;
  assign bus.m_pstrb   = r_m_pstrb;
  assign bus.m_pprot   = r_m_pprot;
  assign bus.s_prdata  = r_s_prdata;
  assign bus.s_pready  = r_s_pready;
  assign bus.s_pslverr = r_s_pslverr;

endmodule

// File: tb/tb_bforge_apb_decoder_n.sv
// tb/tb_bforge_apb_decoder_n.sv - randomized APB decoder bench with a cycle-timeline reference model
module tb_bforge_apb_decoder_n;
  localparam int              N    = 4;
  localparam int              AW   = 32;
  localparam int              DW   = 32;
  localparam int              WIN  = 12;
  localparam logic [AW-1:0]   BASE = '0;
  localparam int              TO   = 16;

  logic PCLK    = 1'b0;
  logic PRESETn = 1'b1;
  always #5 PCLK = ~PCLK;

  bforge_apb_decoder_n_if #(.NUM_TARGETS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  bforge_apb_decoder_n #(
    .NUM_TARGETS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .WIN_BITS(WIN), .BASE_ADDR(BASE), .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK(PCLK),
    .PRESETn(PRESETn),
    .bus(bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int edge_cnt    = 0;
  bit chk_en      = 1'b0;

  // reference model of the transfer in flight, as a timeline from the SETUP edge
  bit            m_valid = 1'b0;
  int            m_start = 0;
  bit            m_hit;
  int            m_idx;
  int            m_acc;
  int            m_resp;
  bit            m_abort;
  logic [DW-1:0] m_rdata;
  bit            m_err;
  bit            m_write;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [3:0]    m_strb;
  logic [2:0]    m_prot;

  // target behaviour knobs
  logic [DW-1:0] tgt_data [N];
  int            tgt_wait = 0;
  bit            tgt_hang = 1'b0;
  bit            tgt_err  = 1'b0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(posedge PCLK) edge_cnt <= edge_cnt + 1;

  // per-cycle comparison against the model timeline
  always @(negedge PCLK) begin : cmp
    int            n;
    bit            win;
    bit            rdy;
    logic [N-1:0]  e_psel;
    if (chk_en) begin
      n      = m_valid ? (edge_cnt - m_start + 1) : 0;
      win    = m_valid && m_hit && (n >= 1) && (n <= 1 + m_acc);
      rdy    = m_valid && (n == m_resp) && !m_abort;
      e_psel = win ? (N'(1) << m_idx) : '0;
      chk("m_psel", 64'(bus.m_psel), 64'(e_psel));
      chk("m_psel_onehot0", 64'($onehot0(bus.m_psel)), 64'd1);
      chk("m_penable", 64'(bus.m_penable), 64'(win && n >= 2));
      chk("s_pready", 64'(bus.s_pready), 64'(rdy));
      chk("s_pslverr", 64'(bus.s_pslverr), 64'(rdy && m_err));
      chk("s_prdata", 64'(bus.s_prdata), rdy ? 64'(m_rdata) : 64'd0);
      if (win) begin
        chk("m_paddr", 64'(bus.m_paddr), 64'(m_addr));
        chk("m_pwrite", 64'(bus.m_pwrite), 64'(m_write));
        chk("m_pwdata", 64'(bus.m_pwdata), 64'(m_wdata));
        chk("m_pstrb", 64'(bus.m_pstrb), 64'(m_strb));
        chk("m_pprot", 64'(bus.m_pprot), 64'(m_prot));
      end
    end
  end

  // targets: the selected one answers after tgt_wait ACCESS wait states; the
  // others toggle ready/error randomly, which the decoder must ignore
  initial begin
    int cnt;
    cnt = 0;
    bus.m_pready  = '0;
    bus.m_pslverr = '0;
    bus.m_prdata  = '0;
    forever begin
      @(posedge PCLK);
      #1;
      if (bus.m_penable && (bus.m_psel != '0)) cnt++;
      else cnt = 0;
      for (int i = 0; i < N; i++) begin
        bus.m_prdata[i*DW +: DW] = tgt_data[i];
        if (bus.m_psel[i]) begin
          bus.m_pready[i]  = bus.m_penable && !tgt_hang && (cnt > tgt_wait);
          bus.m_pslverr[i] = tgt_err;
        end else begin
          bus.m_pready[i]  = 1'($urandom);
          bus.m_pslverr[i] = 1'($urandom);
        end
      end
    end
  end

  // One initiator transfer. Called at posedge+1. drop_j>0: psel falls after
  // edge drop_j; rst_at>0: reset is asserted after edge rst_at.
  task automatic do_txn(input logic [AW-1:0] addr, input bit wr, input logic [DW-1:0] wdata,
                        input logic [3:0] strb, input int waits, input bit hang, input bit terr,
                        input bit fix_en, input logic [DW-1:0] fix, input int drop_j, input int rst_at,
                        output int lat, output logic [DW-1:0] rd, output bit err,
                        output logic [N-1:0] psel_seen);
    longint off;
    bit     tout;
    logic [2:0] prot;
    prot = 3'($urandom);
    for (int i = 0; i < N; i++) tgt_data[i] = $urandom;
    tgt_wait = waits;
    tgt_hang = hang;
    tgt_err  = terr;

    off     = longint'(addr) - longint'(BASE);
    m_hit   = (off >= 0) && ((off >> WIN) < longint'(N));
    m_idx   = m_hit ? int'(off >> WIN) : 0;
    if (fix_en && m_hit) tgt_data[m_idx] = fix;
    tout    = hang || (waits + 1 > TO);
    m_acc   = tout ? TO : waits + 1;
    m_resp  = m_hit ? 2 + m_acc : 2;
    m_rdata = (m_hit && !wr && !tout) ? tgt_data[m_idx] : '0;
    m_err   = !m_hit || tout || terr;
    m_abort = (drop_j >= 1) && (drop_j <= m_resp - 2);
    m_write = wr;
    m_addr  = addr;
    m_wdata = wdata;
    m_strb  = strb;
    m_prot  = prot;
    m_start = edge_cnt + 1;
    m_valid = 1'b1;

    bus.s_psel    = 1'b1;
    bus.s_penable = 1'b0;
    bus.s_pwrite  = wr;
    bus.s_paddr   = addr;
    bus.s_pwdata  = wdata;
    bus.s_pstrb   = strb;
    bus.s_pprot   = prot;
    lat = -1;
    rd  = '0;
    err = 1'b0;
    psel_seen = '0;
    @(posedge PCLK);
    #1;
    bus.s_penable = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge PCLK);
      psel_seen = psel_seen | bus.m_psel;
      if (bus.s_pready && lat < 0) begin
        lat = c;
        rd  = bus.s_prdata;
        err = bus.s_pslverr;
      end
      @(posedge PCLK);
      #1;
      if (rst_at > 0 && c == rst_at) begin
        PRESETn       = 1'b0;
        m_valid       = 1'b0;
        bus.s_psel    = 1'b0;
        bus.s_penable = 1'b0;
        #1;
        chk("rst_m_psel", 64'(bus.m_psel), 64'd0);
        chk("rst_m_penable", 64'(bus.m_penable), 64'd0);
        chk("rst_m_paddr", 64'(bus.m_paddr), 64'd0);
        chk("rst_m_pwdata", 64'(bus.m_pwdata), 64'd0);
        chk("rst_s_pready", 64'(bus.s_pready), 64'd0);
        chk("rst_s_prdata", 64'(bus.s_prdata), 64'd0);
        break;
      end
      if (c == drop_j) begin
        bus.s_psel    = 1'b0;
        bus.s_penable = 1'b0;
      end
      if (lat > 0) break;
      if (drop_j >= 1 && c >= m_resp) break;
    end
    bus.s_psel    = 1'b0;
    bus.s_penable = 1'b0;
  endtask

  initial begin
    int            lat;
    int            exp_lat;
    logic [DW-1:0] rd;
    bit            er;
    logic [N-1:0]  ps;
    logic [AW-1:0] a;
    bit            wr;
    int            drop;

    bus.s_psel    = 1'b0;
    bus.s_penable = 1'b0;
    bus.s_pwrite  = 1'b0;
    bus.s_paddr   = '0;
    bus.s_pwdata  = '0;
    bus.s_pstrb   = '0;
    bus.s_pprot   = '0;
    for (int i = 0; i < N; i++) tgt_data[i] = '0;

    #2 PRESETn = 1'b0;
    #1;
    chk("reset_m_psel", 64'(bus.m_psel), 64'd0);
    chk("reset_m_penable", 64'(bus.m_penable), 64'd0);
    chk("reset_s_pready", 64'(bus.s_pready), 64'd0);
    chk("reset_s_pslverr", 64'(bus.s_pslverr), 64'd0);
    chk("reset_s_prdata", 64'(bus.s_prdata), 64'd0);
    repeat (3) @(posedge PCLK);
    #1;
    PRESETn = 1'b1;
    chk_en  = 1'b1;
    @(posedge PCLK);
    #1;

    // read target 2, zero waits
    do_txn(32'h0000_2004, 1'b0, 32'h0, 4'hF, 0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, -1, 0, lat, rd, er, ps);
    chk("t2_read_lat", 64'(lat), 64'd3);
    chk("t2_read_data", 64'(rd), 64'hDEAD_BEEF);
    chk("t2_read_err", 64'(er), 64'd0);
    chk("t2_read_psel", 64'(ps), 64'b0100);

    // write target 0, three waits
    do_txn(32'h0000_0010, 1'b1, 32'h1234_5678, 4'b0011, 3, 1'b0, 1'b0, 1'b0, 32'h0, -1, 0, lat, rd, er, ps);
    chk("t0_write_lat", 64'(lat), 64'd6);
    chk("t0_write_rdata", 64'(rd), 64'd0);
    chk("t0_write_err", 64'(er), 64'd0);
    chk("t0_write_psel", 64'(ps), 64'b0001);

    // unmapped
    do_txn(32'h0000_4000, 1'b0, 32'h0, 4'hF, 0, 1'b0, 1'b0, 1'b0, 32'h0, -1, 0, lat, rd, er, ps);
    chk("miss_lat", 64'(lat), 64'd2);
    chk("miss_err", 64'(er), 64'd1);
    chk("miss_rdata", 64'(rd), 64'd0);
    chk("miss_psel", 64'(ps), 64'd0);

    // target 1 never ready
    do_txn(32'h0000_1000, 1'b0, 32'h0, 4'hF, 0, 1'b1, 1'b0, 1'b0, 32'h0, -1, 0, lat, rd, er, ps);
    chk("timeout_lat", 64'(lat), 64'd18);
    chk("timeout_err", 64'(er), 64'd1);
    chk("timeout_rdata", 64'(rd), 64'd0);
    chk("timeout_psel", 64'(ps), 64'b0010);

    // target 1 error propagates
    do_txn(32'h0000_1008, 1'b0, 32'h0, 4'hF, 0, 1'b0, 1'b1, 1'b0, 32'h0, -1, 0, lat, rd, er, ps);
    chk("slverr_lat", 64'(lat), 64'd3);
    chk("slverr_err", 64'(er), 64'd1);

    // reset in the middle of ACCESS, then a fresh read of target 3
    do_txn(32'h0000_1000, 1'b0, 32'h0, 4'hF, 0, 1'b1, 1'b0, 1'b0, 32'h0, -1, 4, lat, rd, er, ps);
    repeat (2) @(posedge PCLK);
    #1;
    PRESETn = 1'b1;
    @(posedge PCLK);
    #1;
    do_txn(32'h0000_3008, 1'b0, 32'h0, 4'hF, 0, 1'b0, 1'b0, 1'b1, 32'hCAFE_F00D, -1, 0, lat, rd, er, ps);
    chk("post_rst_lat", 64'(lat), 64'd3);
    chk("post_rst_data", 64'(rd), 64'hCAFE_F00D);
    chk("post_rst_psel", 64'(ps), 64'b1000);

    // initiator walks away during the transfer: no response
    do_txn(32'h0000_2000, 1'b1, 32'h5555_AAAA, 4'hF, 2, 1'b0, 1'b0, 1'b0, 32'h0, 1, 0, lat, rd, er, ps);
    chk("abort_no_pready", 64'(lat < 0), 64'd1);
    chk("abort_target_ran", 64'(ps), 64'b0100);

    // back-to-back alternating read/write across all targets
    for (int i = 0; i < 10; i++) begin
      a = AW'(((i % N) << WIN) | ($urandom & 32'hFFC));
      do_txn(a, 1'(i % 2), $urandom, 4'($urandom), int'($urandom_range(0, 3)), 1'b0, 1'($urandom_range(0, 5) == 0),
             1'b0, 32'h0, -1, 0, lat, rd, er, ps);
      chk("b2b_lat", 64'(lat), 64'(m_resp));
      chk("b2b_rdata", 64'(rd), 64'(m_rdata));
      chk("b2b_err", 64'(er), 64'(m_err));
    end

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: a = AW'(32'h4000 + $urandom_range(0, 32'hFFFF));
        1: begin
          a = $urandom;
          if (a < 32'h4000) a = a | 32'h8000_0000;
        end
        default: a = AW'(($urandom_range(0, N - 1) << WIN) | ($urandom & 32'hFFC));
      endcase
      wr   = 1'($urandom);
      drop = ($urandom_range(0, 11) == 0) ? int'($urandom_range(1, 3)) : -1;
      do_txn(a, wr, $urandom, 4'($urandom), int'($urandom_range(0, 5)), 1'($urandom_range(0, 15) == 0),
             1'($urandom_range(0, 7) == 0), 1'b0, 32'h0, drop, 0, lat, rd, er, ps);
      exp_lat = m_abort ? -1 : m_resp;
      chk("rand_lat", 64'(lat), 64'(exp_lat));
      if (!m_abort) begin
        chk("rand_rdata", 64'(rd), 64'(m_rdata));
        chk("rand_err", 64'(er), 64'(m_err));
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge PCLK);
        #1;
      end
    end

    repeat (3) @(posedge PCLK);
    #1;
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
